vscale_csr_rmw_master: RTL and testbench
========================================

VSCALE_CSR_RMW_MASTER -- requirements
Module: vscale_csr_rmw_master

Interface
REQ-001 The block SHALL have the parameters below (name, default, meaning).
- XPR_LEN, 32, data width.
- CSR_ADDR_W, 12, CSR address width.

REQ-002 The block SHALL have the ports below (name, direction, width, meaning).
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, reset: asynchronous, active-low.
- req_valid, in, 1, CSR instruction request valid.
- req_ready, out, 1, block can accept a request.
- req_op, in, 2, 01=RW, 10=RS (set), 11=RC (clear); 00 is illegal.
- req_addr, in, CSR_ADDR_W, target CSR address.
- req_operand, in, XPR_LEN, rs1 value or zero-extended uimm.
- req_src_zero, in, 1, rs1=x0 or uimm=0.
- prv, in, 2, current privilege level.
- kill, in, 1, pipeline flush.
- csr_addr, out, CSR_ADDR_W, address driven to the CSR file.
- csr_en, out, 1, CSR access strobe.
- csr_wen, out, 1, CSR write strobe.
- csr_wdata, out, XPR_LEN, CSR write data.
- csr_rdata, in, XPR_LEN, combinational read data from the CSR file.
- csr_defined, in, 1, address is implemented.
- resp_valid, out, 1, result valid.
- resp_ready, in, 1, consumer accepts the result.
- resp_rdata, out, XPR_LEN, old CSR value (the rd result).
- resp_illegal, out, 1, illegal-instruction trap.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, READ, WRITE, RESP.
REQ-004 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1, registering op, addr, operand, src_zero and prv, and moving to READ.
REQ-005 In READ, csr_en SHALL be 1, csr_wen SHALL be 0, and csr_addr SHALL be the registered addr; csr_rdata and csr_defined SHALL be captured at the end of the cycle.
REQ-006 The write-intent flag SHALL be set when op=RW, or when op is RS/RC and src_zero=0.
REQ-007 The request SHALL be illegal when any of the following holds:
- op=00;
- csr_defined=0;
- addr[9:8] > registered prv;
- write-intent is set and addr[11:10]=2'b11 (read-only range).
REQ-008 The new value SHALL be computed as follows:
- RW: new = operand;
- RS: new = old | operand;
- RC: new = old & ~operand.
All three use the full XPR_LEN width, with no sign handling.
REQ-009 After READ, the FSM SHALL go to WRITE if write-intent is set and the request is legal; otherwise it SHALL go to RESP.
REQ-010 In WRITE, csr_en, csr_wen and csr_wdata=new SHALL be asserted for exactly one cycle, then the FSM SHALL go to RESP.
REQ-011 csr_wen SHALL never be 1 outside WRITE and SHALL never be 1 for an illegal request.
REQ-012 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_illegal SHALL be held stable until resp_ready=1; when resp_ready=1 the FSM SHALL return to IDLE.
REQ-013 resp_rdata SHALL be 0 when resp_illegal=1.
REQ-014 Latency from the acceptance edge SHALL be:
- write-intent: resp_valid on the 3rd cycle after acceptance;
- no write-intent, or illegal: resp_valid on the 2nd cycle after acceptance.
Throughput SHALL be at most one request per 3 cycles (back-to-back: IDLE re-entered on the resp_ready edge).
REQ-015 kill=1 in READ or WRITE SHALL suppress csr_wen in that cycle and return the FSM to IDLE next cycle with no response.
REQ-016 kill in IDLE or RESP SHALL have no effect.
REQ-017 kill and req_valid both 1 in IDLE SHALL still accept the request.
REQ-018 When csr_en=0, csr_addr and csr_wdata SHALL be 0.

Reset
REQ-019 While reset=0, all state SHALL clear immediately (asynchronously), independent of clk.
REQ-020 Reset values SHALL be:
- FSM = IDLE;
- req_ready = 1;
- csr_en, csr_wen, resp_valid, resp_illegal = 0;
- csr_addr, csr_wdata, resp_rdata = 0.
REQ-021 Reset asserted during WRITE SHALL deassert csr_wen immediately, and no response SHALL be produced for the aborted request.

Verification
REQ-022 A bench SHALL cover at least the following directed scenarios:
- RS on 0x340 with old=0x0000_00F0, operand=0x0F, prv=3 -> one write of 0x0000_00FF; resp_rdata=0x0000_00F0 on cycle 3.
- RC on 0x340 with old=0xFFFF_FFFF, operand=0x1, src_zero=0 -> wdata=0xFFFF_FFFE; resp_illegal=0.
- RS on 0xF10 (read-only) with src_zero=1 -> no csr_wen; resp_rdata=old on cycle 2; resp_illegal=0. Same with src_zero=0 -> resp_illegal=1, resp_rdata=0.
- RW to 0x300 with prv=0 -> resp_illegal=1, no write. Undefined address (csr_defined=0) -> resp_illegal=1.
- kill in WRITE -> csr_wen=0, no resp_valid, req_ready=1 next cycle. resp_ready held 0 for 5 cycles -> resp_rdata stable, req_ready=0 throughout.
- reset=0 pulse mid-WRITE -> csr_wen falls with no clk edge; FSM in IDLE after release.

Source files
------------

// File: rtl/vscale_csr_rmw_master.sv
// vscale_csr_rmw_master: runs one CSR read-modify-write per request.
// Privilege, read-only and implemented-address checks complete before any write is issued.
module vscale_csr_rmw_master #(
  parameter int XPR_LEN    = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [CSR_ADDR_W-1:0] req_addr,
  input  logic [XPR_LEN-1:0]    req_operand,
  input  logic                  req_src_zero,
  input  logic [1:0]            prv,
  input  logic                  kill,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic                  csr_en,
  output logic                  csr_wen,
  output logic [XPR_LEN-1:0]    csr_wdata,
  input  logic [XPR_LEN-1:0]    csr_rdata,
  input  logic                  csr_defined,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XPR_LEN-1:0]    resp_rdata,
  output logic                  resp_illegal
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t                state_q;
  logic [1:0]            op_q, prv_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [XPR_LEN-1:0]    operand_q, wdata_q, rdata_q;
  logic                  src_zero_q, ready_q, en_q, wen_q, valid_q, illegal_q;
  logic                  write_intent, illegal;
  logic [XPR_LEN-1:0]    new_d;
  always_comb begin
    write_intent = op_q == 2'b01 || (op_q != 2'b00 && !src_zero_q);
    illegal = op_q == 2'b00 || !csr_defined || addr_q[9:8] > prv_q ||
              (write_intent && addr_q[11:10] == 2'b11);
    new_d = op_q == 2'b01 ? operand_q :
            op_q == 2'b10 ? csr_rdata | operand_q : csr_rdata & ~operand_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      op_q       <= 2'b00;
      prv_q      <= 2'b00;
      addr_q     <= '0;
      operand_q  <= '0;
      src_zero_q <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b1;
      en_q       <= 1'b0;
      wen_q      <= 1'b0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_q    <= READ;
          op_q       <= req_op;
          addr_q     <= req_addr;
          operand_q  <= req_operand;
          src_zero_q <= req_src_zero;
          prv_q      <= prv;
          ready_q    <= 1'b0;
          en_q       <= 1'b1;
        end
        READ: begin
          if (kill) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            en_q    <= 1'b0;
          end else if (write_intent && !illegal) begin
            state_q   <= WRITE;
            wen_q     <= 1'b1;
            wdata_q   <= new_d;
            rdata_q   <= csr_rdata;
            illegal_q <= 1'b0;
          end else begin
            state_q   <= RESP;
            en_q      <= 1'b0;
            valid_q   <= 1'b1;
            rdata_q   <= illegal ? '0 : csr_rdata;
            illegal_q <= illegal;
          end
        end
        WRITE: begin
          state_q <= kill ? IDLE : RESP;
          ready_q <= kill;
          valid_q <= !kill;
          en_q    <= 1'b0;
          wen_q   <= 1'b0;
          wdata_q <= '0;
        end
        default: if (resp_ready) begin
          state_q   <= IDLE;
          ready_q   <= 1'b1;
          valid_q   <= 1'b0;
          illegal_q <= 1'b0;
          rdata_q   <= '0;
        end
      endcase
    end
  end
  // kill must cancel the write strobe within the same cycle, so it gates the registered enable
  assign csr_wen      = wen_q & ~kill;
  assign csr_en       = en_q;
  assign csr_addr     = en_q ? addr_q : '0;
  assign csr_wdata    = wdata_q;
  assign req_ready    = ready_q;
  assign resp_valid   = valid_q;
  assign resp_rdata   = rdata_q;
  assign resp_illegal = illegal_q;
endmodule

// File: tb/tb_vscale_csr_rmw_master.sv
// tb_vscale_csr_rmw_master: directed and random CSR RMW transactions against a transaction-level model.
module tb_vscale_csr_rmw_master;
  logic        clk = 0, reset = 0, req_valid = 0, req_src_zero = 0, kill = 0, resp_ready = 0;
  logic [1:0]  req_op = 0, prv = 0;
  logic [11:0] req_addr = 0;
  logic [31:0] req_operand = 0;
  logic        req_ready, csr_en, csr_wen, resp_valid, resp_illegal, csr_defined;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, resp_rdata;
  logic [31:0] mem [4096];
  bit          def [4096];
  int          n_chk = 0, n_err = 0;

  vscale_csr_rmw_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_operand(req_operand),
    .req_src_zero(req_src_zero), .prv(prv), .kill(kill), .csr_addr(csr_addr),
    .csr_en(csr_en), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_defined(csr_defined), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;
  assign csr_rdata   = mem[csr_addr];
  assign csr_defined = def[csr_addr];
  always @(posedge clk) if (csr_wen) mem[csr_addr] <= csr_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [11:0] a, input logic [31:0] opnd,
                     input logic sz, input logic [1:0] pv, input int kill_c,
                     input bit kill_acc, input int hold);
    logic [31:0] old, nv, wd;
    bit wi, ill, wr, killed;
    int lat, got, nw;
    old = mem[a];
    wi  = op == 2'd1 || (op != 2'd0 && !sz);
    ill = op == 2'd0 || !def[a] || a[9:8] > pv || (wi && a[11:10] == 2'd3);
    case (op)
      2'd1:    nv = opnd;
      2'd2:    nv = old | opnd;
      default: nv = old & ~opnd;
    endcase
    wr     = wi && !ill;
    lat    = wr ? 3 : 2;
    killed = kill_c >= 1 && kill_c < lat;
    got = 0; nw = 0; wd = 0;
    chk("idle_ready", req_ready, 1);
    req_valid = 1; req_op = op; req_addr = a; req_operand = opnd; req_src_zero = sz; prv = pv;
    kill = kill_acc;
    @(posedge clk);
    for (int c = 1; c <= 6 && got == 0; c++) begin
      @(negedge clk);
      req_valid = 0; req_op = 2'($urandom); req_addr = 12'($urandom);
      req_operand = $urandom; req_src_zero = 1'($urandom); prv = 2'($urandom);
      kill = c == kill_c;
      #1;
      if (c == 1) begin
        chk("rd_en", csr_en, 1); chk("rd_addr", csr_addr, a); chk("rd_wen", csr_wen, 0);
      end
      if (csr_wen) begin
        nw++; wd = csr_wdata; chk("wr_addr", csr_addr, a);
      end
      if (!csr_en) begin
        chk("off_addr", csr_addr, 0); chk("off_wdata", csr_wdata, 0);
      end
      if (killed && c == kill_c + 1) chk("kill_ready", req_ready, 1);
      if (resp_valid) got = c;
    end
    if (killed) begin
      chk("kill_noresp", got, 0);
      chk("kill_nowrite", nw, 0);
    end else begin
      chk("latency", got, lat);
      chk("n_writes", nw, {31'd0, wr});
      if (wr) chk("wdata", wd, nv);
      chk("illegal", resp_illegal, {31'd0, ill});
      chk("rdata", resp_rdata, ill ? 32'd0 : old);
      for (int d = 0; d < hold; d++) begin
        @(negedge clk); #1;
        chk("hold_valid", resp_valid, 1);
        chk("hold_rdata", resp_rdata, ill ? 32'd0 : old);
        chk("hold_ready", req_ready, 0);
      end
      resp_ready = 1;
      @(posedge clk); #1 resp_ready = 0; kill = 0;
      @(negedge clk); #1;
      chk("back_idle", req_ready, 1);
      chk("resp_clear", resp_valid, 0);
    end
    kill = 0;
    chk("csr_value", mem[a], (wr && !killed) ? nv : old);
  endtask

  task automatic reset_mid_write();
    mem[12'h340] = 0; def[12'h340] = 1;
    req_valid = 1; req_op = 2'd2; req_addr = 12'h340; req_operand = 32'hA; req_src_zero = 0; prv = 3;
    @(posedge clk);
    @(negedge clk); req_valid = 0;
    @(negedge clk); #1;
    chk("pre_rst_wen", csr_wen, 1);
    reset = 0; #1;
    chk("rst_wen", csr_wen, 0);
    chk("rst_en", csr_en, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk); reset = 1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_noresp", resp_valid, 0);
      chk("rst_idle", req_ready, 1);
    end
    chk("rst_nowrite", mem[12'h340], 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      def[i] = $urandom_range(0, 9) != 0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_csr_en", csr_en, 0);
    chk("rst_csr_wen", csr_wen, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_illegal", resp_illegal, 0);
    chk("rst_csr_addr", csr_addr, 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    @(negedge clk); reset = 1;
    @(negedge clk);
    def[12'h340] = 1; mem[12'h340] = 32'h0000_00F0;
    run(2'd2, 12'h340, 32'h0F, 0, 3, 0, 0, 0);
    mem[12'h340] = 32'hFFFF_FFFF;
    run(2'd3, 12'h340, 32'h1, 0, 3, 0, 0, 0);
    def[12'hF10] = 1; mem[12'hF10] = 32'h1234_5678;
    run(2'd2, 12'hF10, 32'h0, 1, 3, 0, 0, 0);
    run(2'd2, 12'hF10, 32'h5, 0, 3, 0, 0, 0);
    def[12'h300] = 1;
    run(2'd1, 12'h300, 32'h7, 0, 0, 0, 0, 0);
    def[12'h123] = 0;
    run(2'd1, 12'h123, 32'h7, 0, 3, 0, 0, 0);
    run(2'd0, 12'h340, 32'h7, 0, 3, 0, 0, 0);
    run(2'd2, 12'h340, 32'h100, 0, 3, 2, 0, 0);
    run(2'd1, 12'h340, 32'h55, 0, 3, 1, 0, 0);
    run(2'd1, 12'h340, 32'h66, 0, 3, 3, 0, 1);
    run(2'd1, 12'h340, 32'h77, 0, 3, 0, 1, 0);
    run(2'd1, 12'h340, 32'hABCD, 0, 3, 0, 0, 5);
    reset_mid_write();
    for (int t = 0; t < 300; t++)
      run(2'($urandom), 12'($urandom), $urandom, $urandom_range(0, 3) == 0, 2'($urandom),
          $urandom_range(0, 9) < 2 ? int'($urandom_range(1, 3)) : 0,
          $urandom_range(0, 9) == 0, int'($urandom_range(0, 3)));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
